// File: rtl/lock_requester_if.sv
// lock_requester_if: task-side request/unlock handshakes plus the
// command and acknowledgement streams to the lock interconnect.
interface lock_requester_if;
    logic        acc_lock_valid;
    logic        acc_lock_ready;
    logic [7:0]  acc_lock_id;
    logic        acc_unlock_valid;
    logic        acc_unlock_ready;
    logic        lock_held;
    logic        lock_fail;
    logic [63:0] cmdStream_TDATA;
    logic        cmdStream_TVALID;
    logic        cmdStream_TREADY;
    logic [3:0]  cmdStream_TID;
    logic [7:0]  ackStream_TDATA;
    logic        ackStream_TVALID;
    logic        ackStream_TREADY;
    logic [3:0]  ackStream_TDEST;
    logic        ackStream_TLAST;

    // TLAST is always 1 and never inspected, so the requester does not take it.
    modport master (
        input  acc_lock_valid, acc_lock_id, acc_unlock_valid,
        input  cmdStream_TREADY,
        input  ackStream_TDATA, ackStream_TVALID, ackStream_TDEST,
        output acc_lock_ready, acc_unlock_ready, lock_held, lock_fail,
        output cmdStream_TDATA, cmdStream_TVALID, cmdStream_TID,
        output ackStream_TREADY
    );

    modport slave (
        output acc_lock_valid, acc_lock_id, acc_unlock_valid,
        output cmdStream_TREADY,
        output ackStream_TDATA, ackStream_TVALID, ackStream_TDEST,
        output ackStream_TLAST,
        input  acc_lock_ready, acc_unlock_ready, lock_held, lock_fail,
        input  cmdStream_TDATA, cmdStream_TVALID, cmdStream_TID,
        input  ackStream_TREADY
    );
endinterface

// File: rtl/lock_requester.sv
// lock_requester: lock/unlock command initiator with deny back-off.
// Optional retry limit enabled by defining LOCK_REQUESTER_RETRY_LIMIT_EN.
module lock_requester #(
    parameter int ACC_ID         = 0,
    parameter int BACKOFF_CYCLES = 16,
    parameter int MAX_RETRIES    = 255
) (
    input  logic             clk,
    input  logic             rstn,
    lock_requester_if.master bus
);
`ifdef LOCK_REQUESTER_RETRY_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif
    localparam logic [3:0]  ID        = 4'(ACC_ID);
    localparam logic [15:0] BOFF      = 16'(BACKOFF_CYCLES);
    localparam logic [7:0]  RCAP      = 8'(MAX_RETRIES);
    localparam logic [7:0]  OP_LOCK   = 8'h04;
    localparam logic [7:0]  OP_UNLOCK = 8'h06;

    typedef enum logic [2:0] {
        IDLE, SEND_LOCK, WAIT_ACK, BACKOFF, LOCKED, SEND_UNLOCK
    } state_t;

    state_t      state;
    logic [7:0]  lock_id;
    logic [15:0] boff_cnt;
    logic [7:0]  retries;
    logic [7:0]  retries_inc;
    logic        cmd_hs;
    logic        ack_hit;
    logic        grant;

    assign cmd_hs      = bus.cmdStream_TVALID & bus.cmdStream_TREADY;
    assign ack_hit     = bus.ackStream_TVALID & bus.ackStream_TREADY
                       & (bus.ackStream_TDEST == ID);
    assign grant       = bus.ackStream_TDATA == 8'd1;
    assign retries_inc = (retries == 8'hFF) ? retries : retries + 8'd1;
    assign bus.cmdStream_TID = ID;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state                <= IDLE;
            lock_id              <= '0;
            boff_cnt             <= '0;
            retries              <= '0;
            bus.acc_lock_ready   <= 1'b1;
            bus.acc_unlock_ready <= 1'b0;
            bus.lock_held        <= 1'b0;
            bus.lock_fail        <= 1'b0;
            bus.cmdStream_TVALID <= 1'b0;
            bus.cmdStream_TDATA  <= '0;
            bus.ackStream_TREADY <= 1'b0;
        end else begin
            bus.lock_fail <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.acc_lock_valid) begin
                        lock_id              <= bus.acc_lock_id;
                        bus.acc_lock_ready   <= 1'b0;
                        bus.cmdStream_TVALID <= 1'b1;
                        bus.cmdStream_TDATA  <= {48'd0, bus.acc_lock_id, OP_LOCK};
                        state                <= SEND_LOCK;
                    end
                end
                SEND_LOCK: begin
                    if (cmd_hs) begin
                        bus.cmdStream_TVALID <= 1'b0;
                        bus.ackStream_TREADY <= 1'b1;
                        state                <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // Beats for other accelerators are consumed and dropped.
                    if (ack_hit) begin
                        bus.ackStream_TREADY <= 1'b0;
                        if (grant) begin
                            retries              <= '0;
                            bus.lock_held        <= 1'b1;
                            bus.acc_unlock_ready <= 1'b1;
                            state                <= LOCKED;
                        end else if (LIMIT_EN && retries_inc == RCAP) begin
                            retries            <= '0;
                            bus.lock_fail      <= 1'b1;
                            bus.acc_lock_ready <= 1'b1;
                            state              <= IDLE;
                        end else begin
                            retries  <= retries_inc;
                            boff_cnt <= BOFF;
                            state    <= BACKOFF;
                        end
                    end
                end
                BACKOFF: begin
                    if (boff_cnt == 16'd0) begin
                        bus.cmdStream_TVALID <= 1'b1;
                        bus.cmdStream_TDATA  <= {48'd0, lock_id, OP_LOCK};
                        state                <= SEND_LOCK;
                    end else begin
                        boff_cnt <= boff_cnt - 16'd1;
                    end
                end
                LOCKED: begin
                    if (bus.acc_unlock_valid) begin
                        bus.lock_held        <= 1'b0;
                        bus.acc_unlock_ready <= 1'b0;
                        bus.cmdStream_TVALID <= 1'b1;
                        bus.cmdStream_TDATA  <= {48'd0, lock_id, OP_UNLOCK};
                        state                <= SEND_UNLOCK;
                    end
                end
                SEND_UNLOCK: begin
                    if (cmd_hs) begin
                        bus.cmdStream_TVALID <= 1'b0;
                        bus.acc_lock_ready   <= 1'b1;
                        retries              <= '0;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lock_requester.sv
// tb_lock_requester: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_lock_requester;
    localparam int ACC_ID = 3;
    localparam int BOFF   = 4;
    localparam int MAXR   = 2;
`ifdef LOCK_REQUESTER_RETRY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    lock_requester_if bus ();

    lock_requester #(
        .ACC_ID(ACC_ID),
        .BACKOFF_CYCLES(BOFF),
        .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(string name, logic [79:0] act, logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending beats queue, ownership, ack wait, back-off countdown.
    bit          m_owned = 0;
    bit          m_wait  = 0;
    bit          m_fail  = 0;
    int          m_boff  = -1;
    int          m_retries = 0;
    logic [7:0]  m_id    = '0;
    logic [63:0] m_q[$];
    bit          hs_lock, hs_unlock, hs_ack;

    function automatic bit m_idle();
        return !m_owned && m_q.size() == 0 && !m_wait && m_boff < 0;
    endfunction

    always @(posedge clk) begin : model
        logic [63:0] b;
        hs_lock   = 0;
        hs_unlock = 0;
        hs_ack    = 0;
        if (!rstn) begin
            m_owned = 0; m_wait = 0; m_fail = 0;
            m_boff = -1; m_retries = 0;
            m_q.delete();
        end else begin
            m_fail = 0;
            if (m_idle()) begin
                if (bus.acc_lock_valid) begin
                    hs_lock = 1;
                    m_id = bus.acc_lock_id;
                    m_q.push_back({48'd0, m_id, 8'h04});
                end
            end else if (m_q.size() != 0) begin
                if (bus.cmdStream_TREADY) begin
                    b = m_q.pop_front();
                    if (b[7:0] == 8'h04) m_wait = 1;
                    else m_retries = 0;
                end
            end else if (m_wait) begin
                if (bus.ackStream_TVALID) begin
                    hs_ack = 1;
                    if (bus.ackStream_TDEST == 4'(ACC_ID)) begin
                        m_wait = 0;
                        if (bus.ackStream_TDATA == 8'd1) begin
                            m_owned = 1;
                            m_retries = 0;
                        end else begin
                            m_retries = (m_retries < 255) ? m_retries + 1 : 255;
                            if (LIMIT && m_retries == MAXR) begin
                                m_fail = 1;
                                m_retries = 0;
                            end else begin
                                m_boff = BOFF;
                            end
                        end
                    end
                end
            end else if (m_boff >= 0) begin
                if (m_boff == 0) begin
                    m_boff = -1;
                    m_q.push_back({48'd0, m_id, 8'h04});
                end else begin
                    m_boff--;
                end
            end else if (m_owned && bus.acc_unlock_valid) begin
                hs_unlock = 1;
                m_owned = 0;
                m_q.push_back({48'd0, m_id, 8'h06});
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [79:0] act, exp;
        logic [63:0] head;
        if (chk_en) begin
            head = (m_q.size() != 0) ? m_q[0] : 64'd0;
            exp = {6'd0, m_idle(), m_owned, m_owned, m_fail,
                   m_q.size() != 0, m_wait, 4'(ACC_ID), head};
            act = {6'd0, bus.acc_lock_ready, bus.acc_unlock_ready,
                   bus.lock_held, bus.lock_fail, bus.cmdStream_TVALID,
                   bus.ackStream_TREADY, bus.cmdStream_TID,
                   bus.cmdStream_TVALID ? bus.cmdStream_TDATA : 64'd0};
            check("cycle_model", act, exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_lock(input logic [7:0] id);
        bus.acc_lock_valid = 1;
        bus.acc_lock_id    = id;
        tick();
        bus.acc_lock_valid = 0;
    endtask

    task automatic send_beat();
        bus.cmdStream_TREADY = 1;
        tick();
        bus.cmdStream_TREADY = 0;
    endtask

    task automatic ack(input logic [3:0] dest, input logic [7:0] data);
        bus.ackStream_TVALID = 1;
        bus.ackStream_TDEST  = dest;
        bus.ackStream_TDATA  = data;
        tick();
        bus.ackStream_TVALID = 0;
    endtask

    task automatic unlock_quick();
        bus.acc_unlock_valid = 1;
        tick();
        bus.acc_unlock_valid = 0;
        send_beat();
    endtask

    int beats;

    initial begin
        bus.acc_lock_valid   = 0;
        bus.acc_lock_id      = '0;
        bus.acc_unlock_valid = 0;
        bus.cmdStream_TREADY = 0;
        bus.ackStream_TDATA  = '0;
        bus.ackStream_TVALID = 0;
        bus.ackStream_TDEST  = '0;
        bus.ackStream_TLAST  = 1;

        tick();
        chk_en = 1;
        tick();
        rstn = 1;
        repeat (2) tick();
        check("rst_lock_ready", 80'(bus.acc_lock_ready), 80'd1);
        check("rst_tvalid", 80'(bus.cmdStream_TVALID), 80'd0);
        check("rst_ack_ready", 80'(bus.ackStream_TREADY), 80'd0);
        check("rst_held", 80'(bus.lock_held), 80'd0);
        check("rst_tid", 80'(bus.cmdStream_TID), 80'd3);

        // Plain grant, then stalled unlock.
        start_lock(8'h00);
        check("lock_tvalid", 80'(bus.cmdStream_TVALID), 80'd1);
        check("lock_tdata", 80'(bus.cmdStream_TDATA), 80'h4);
        send_beat();
        check("wait_ack_ready", 80'(bus.ackStream_TREADY), 80'd1);
        ack(4'd3, 8'd1);
        check("grant_held", 80'(bus.lock_held), 80'd1);
        bus.acc_lock_valid = 1;
        repeat (2) tick();
        bus.acc_lock_valid = 0;
        check("locked_no_relock", 80'(bus.cmdStream_TVALID), 80'd0);
        bus.acc_unlock_valid = 1;
        tick();
        bus.acc_unlock_valid = 0;
        for (int i = 0; i < 10; i++) begin
            check("unlock_stall_data",
                  {15'd0, bus.cmdStream_TVALID, bus.cmdStream_TDATA},
                  {15'd0, 1'b1, 64'h6});
            tick();
        end
        send_beat();
        check("unlock_idle_ready", 80'(bus.acc_lock_ready), 80'd1);
        check("unlock_held", 80'(bus.lock_held), 80'd0);
        check("unlock_tvalid", 80'(bus.cmdStream_TVALID), 80'd0);

        // Deny then grant: retry valid exactly 6 cycles after the deny.
        start_lock(8'h5A);
        send_beat();
        ack(4'd3, 8'd0);
        repeat (4) tick();
        check("backoff_quiet", 80'(bus.cmdStream_TVALID), 80'd0);
        tick();
        check("retry_valid", 80'(bus.cmdStream_TVALID), 80'd1);
        check("retry_tdata", 80'(bus.cmdStream_TDATA), 80'h5A04);
        send_beat();
        ack(4'd3, 8'd1);
        check("retry_grant_held", 80'(bus.lock_held), 80'd1);
        unlock_quick();

        // Foreign ack is swallowed.
        start_lock(8'h33);
        send_beat();
        ack(4'd5, 8'd1);
        check("foreign_held", 80'(bus.lock_held), 80'd0);
        repeat (3) tick();
        check("foreign_still_wait", 80'(bus.ackStream_TREADY), 80'd1);
        ack(4'd3, 8'd1);
        check("foreign_then_grant", 80'(bus.lock_held), 80'd1);

        // Reset while owning the lock.
        rstn = 0;
        tick();
        rstn = 1;
        check("midrst_held", 80'(bus.lock_held), 80'd0);
        check("midrst_ready", 80'(bus.acc_lock_ready), 80'd1);
        check("midrst_tvalid", 80'(bus.cmdStream_TVALID), 80'd0);

        // Two denies: fail in the limit build, keep retrying otherwise.
        start_lock(8'h11);
        send_beat();
        ack(4'd3, 8'd2);
        repeat (5) tick();
        check("retry2_valid", 80'(bus.cmdStream_TVALID), 80'd1);
        send_beat();
        ack(4'd3, 8'd0);
`ifdef LOCK_REQUESTER_RETRY_LIMIT_EN
        check("fail_pulse", 80'(bus.lock_fail), 80'd1);
        check("fail_ready", 80'(bus.acc_lock_ready), 80'd1);
        tick();
        check("fail_one_cycle", 80'(bus.lock_fail), 80'd0);
        beats = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cmdStream_TVALID) beats++;
        end
        check("fail_no_beats", 80'(beats), 80'd0);
`else
        check("no_fail_default", 80'(bus.lock_fail), 80'd0);
        repeat (5) tick();
        check("retry3_valid", 80'(bus.cmdStream_TVALID), 80'd1);
        send_beat();
        ack(4'd3, 8'd1);
        check("retry3_held", 80'(bus.lock_held), 80'd1);
        unlock_quick();
`endif

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            tick();
            rstn = ($urandom_range(0, 399) != 0);
            if (bus.acc_lock_valid && hs_lock) bus.acc_lock_valid = 0;
            if (bus.acc_unlock_valid && hs_unlock) bus.acc_unlock_valid = 0;
            if (bus.ackStream_TVALID && hs_ack) bus.ackStream_TVALID = 0;
            if (!bus.acc_lock_valid && $urandom_range(0, 3) == 0) begin
                bus.acc_lock_valid = 1;
                bus.acc_lock_id = 8'($urandom);
            end
            if (!bus.acc_unlock_valid && $urandom_range(0, 5) == 0)
                bus.acc_unlock_valid = 1;
            if (!bus.ackStream_TVALID && $urandom_range(0, 2) == 0) begin
                bus.ackStream_TVALID = 1;
                bus.ackStream_TDEST = ($urandom_range(0, 3) == 0) ?
                                      4'($urandom) : 4'(ACC_ID);
                bus.ackStream_TDATA = 8'($urandom_range(0, 3) == 0 ? 2 :
                                         $urandom_range(0, 1));
            end
            bus.cmdStream_TREADY = 1'($urandom);
        end
        rstn = 1;
        bus.acc_lock_valid = 0;
        bus.acc_unlock_valid = 0;
        bus.ackStream_TVALID = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lock_requester.md
# lock_requester

Accelerator-side initiator for the hardware lock protocol. It turns local lock and unlock requests into 64-bit command beats for the Lock manager, consumes the 8-bit grant/deny acknowledgements, and retries denied locks after a programmable back-off. One instance sits inside each accelerator wrapper, between the task logic and the lock interconnect.

## Interface
Parameters:
- ACC_ID, 0: 4-bit accelerator ID; driven on cmdStream_TID and expected on ackStream_TDEST.
- BACKOFF_CYCLES, 16: idle cycles between a deny and the next lock retry; range 1..65535.
- MAX_RETRIES, 255: denies tolerated before failure; used only with LOCK_REQUESTER_RETRY_LIMIT_EN.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  synchronous reset, active-low.
- acc_lock_valid  in  1  lock request; held until acc_lock_ready.
- acc_lock_ready  out  1  request accepted.
- acc_lock_id  in  8  lock ID; sampled on lock acceptance.
- acc_unlock_valid  in  1  unlock request; held until acc_unlock_ready.
- acc_unlock_ready  out  1  unlock accepted.
- lock_held  out  1  high while the lock is owned.
- lock_fail  out  1  one-cycle pulse when the retry limit is exhausted (limit build only).
- cmdStream_TDATA  out  64  command beat.
- cmdStream_TVALID  out  1  command valid.
- cmdStream_TREADY  in  1  command accepted.
- cmdStream_TID  out  4  constant ACC_ID.
- ackStream_TDATA  in  8  acknowledgement: 1 = granted, 0 = denied.
- ackStream_TVALID  in  1  acknowledgement valid.
- ackStream_TREADY  out  1  acknowledgement accepted.
- ackStream_TDEST  in  4  destination ID.
- ackStream_TLAST  in  1  always 1; not checked.

## Operation
- Command beat: TDATA[7:0] = opcode (0x04 lock, 0x06 unlock), TDATA[15:8] = latched lock ID, TDATA[63:16] = 0.
- States: IDLE, SEND_LOCK, WAIT_ACK, BACKOFF, LOCKED, SEND_UNLOCK.
- IDLE: acc_lock_ready = 1. On acc_lock_valid, latch the ID and go to SEND_LOCK. Unlock requests in IDLE are not accepted (acc_unlock_ready = 0).
- SEND_LOCK: TVALID = 1 with the lock opcode. On a TREADY handshake, go to WAIT_ACK.
- WAIT_ACK: ackStream_TREADY = 1.
  - Beat with TDEST == ACC_ID and TDATA == 1: go to LOCKED.
  - Beat with TDEST == ACC_ID and TDATA == 0: increment the retry counter and go to BACKOFF.
  - Beat with TDEST != ACC_ID: consume and discard; stay in WAIT_ACK.
  - TDATA values other than 0 or 1 count as a deny.
- BACKOFF: a 16-bit down-counter is loaded with BACKOFF_CYCLES on entry. When it reaches 0, go to SEND_LOCK.
- LOCKED: lock_held = 1 and acc_unlock_ready = 1. On acc_unlock_valid, go to SEND_UNLOCK. A new acc_lock_valid is not accepted here.
- SEND_UNLOCK: TVALID = 1 with the unlock opcode. On a TREADY handshake, return to IDLE. No acknowledgement is expected.
- The retry counter is 8 bits, saturating, and clears on entry to LOCKED or IDLE.
- ackStream_TREADY = 0 in every state except WAIT_ACK.

## Timing
- Reset values: all outputs 0, except cmdStream_TID = ACC_ID and acc_lock_ready = 1. State = IDLE, counters = 0.
- Reset mid-operation: the FSM returns to IDLE immediately and lock_held drops. No unlock is issued; software is responsible for lock-manager consistency.
- Lock accepted at cycle N: cmdStream_TVALID is high from cycle N+1.
- TVALID and TDATA are held stable until TREADY is sampled high.
- A grant accepted at cycle M: lock_held is high from cycle M+1.
- A deny accepted at cycle M: the retry command has TVALID high at cycle M+BACKOFF_CYCLES+2.
- Unlock accepted at cycle U: the unlock beat has TVALID high from U+1; acc_lock_ready is high again the cycle after the handshake.
- Simultaneous TVALID and TREADY in the same cycle count as one transfer. Back-to-back transfers are never emitted.

## Configuration
- LOCK_REQUESTER_RETRY_LIMIT_EN defined:
  - A deny that makes the retry count equal MAX_RETRIES goes to IDLE instead of BACKOFF.
  - lock_fail pulses for one cycle as IDLE is entered.
- LOCK_REQUESTER_RETRY_LIMIT_EN undefined:
  - Retries continue indefinitely.
  - lock_fail is tied to 0.

## Test plan
- Reset, then idle for 2 cycles: acc_lock_ready = 1, cmdStream_TVALID = 0, ackStream_TREADY = 0, lock_held = 0.
- ACC_ID = 3, lock ID 0, grant: beat TDATA = 0x4, TID = 3; reply TDATA = 1, TDEST = 3; lock_held = 1 the next cycle.
- Deny then grant, BACKOFF_CYCLES = 4: after reply TDATA = 0, a second 0x4 beat has TVALID high exactly 6 cycles after the deny handshake; after the grant, lock_held = 1.
- Foreign ack: TDEST = 5 with TDATA = 1 while ACC_ID = 3: ack consumed, lock_held stays 0, FSM stays in WAIT_ACK until a matching ack arrives.
- Unlock with cmdStream_TREADY held low for 10 cycles: TDATA = 0x6 stays stable throughout; returns to IDLE after TREADY; lock_held = 0.
- LOCK_REQUESTER_RETRY_LIMIT_EN with MAX_RETRIES = 2: two denies give a one-cycle lock_fail pulse, then acc_lock_ready = 1 and no further command beats.
